// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding, register-specifier width and the bubble value
// that a flushed inter-stage buffer loads.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // A flushed buffer loads all zeros, which decodes as a no-op with no
    // memory read, no branch and no register write.
    localparam logic [31:0] BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Pure combinational event decode for the pipeline sequencer:
//   taken - branch in MEM whose EX/MEM zero flag is set
//   lu    - load in EX writing a register that the ID instruction reads
// Register $zero is never a hazard.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_W = pipeline_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zf,
    output logic             lu,
    output logic             taken
);

    logic rd_nonzero_s;
    logic rs_match_s;
    logic rt_match_s;

    assign rd_nonzero_s = (ex_rd != {REG_W{1'b0}});
    assign rs_match_s   = (ex_rd == id_rs);
    assign rt_match_s   = id_uses_rt & (ex_rd == id_rt);

    assign lu    = ex_mem_read & rd_nonzero_s & (rs_match_s | rt_match_s);
    assign taken = mem_branch & mem_zf;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Buffers: a = IF/ID, b = ID/EX, c = EX/MEM, d = MEM/WB.
// Arbitration: memory hold > taken branch > load-use bubble.
// Control outputs are combinational from state and inputs; they act at
// the next rising edge. A watchdog flags runs of HOLD_MAX hold cycles.
// Optional feature macro: PIPELINE_CTRL_PERF_EN (adds perf counters).
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W    = pipeline_pkg::REG_W,
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zf,
    input  logic             mem_hold,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             buf_a_en,
    output logic             buf_b_en,
    output logic             buf_c_en,
    output logic             buf_d_en,
    output logic             buf_a_flush,
    output logic             buf_b_flush,
    output logic             buf_c_flush,
    output logic [1:0]       state,
    output logic             hold_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_hold_cnt
`endif
);

    // Timeout sets on the edge that completes the HOLD_MAX-th hold cycle.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wd_r;
    logic             timeout_r;
    logic             lu_s;
    logic             taken_s;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .mem_branch  (mem_branch),
        .mem_zf      (mem_zf),
        .lu          (lu_s),
        .taken       (taken_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control decode; HOLD release applies RUN rules so a
    // held taken branch is still redirected.
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        buf_a_en      = 1'b1;
        buf_b_en      = 1'b1;
        buf_c_en      = 1'b1;
        buf_d_en      = 1'b1;
        buf_a_flush   = 1'b0;
        buf_b_flush   = 1'b0;
        buf_c_flush   = 1'b0;
        state_next_s  = ST_RUN;
        if (rst) begin
            pc_en       = 1'b0;
            buf_a_en    = 1'b0;
            buf_b_en    = 1'b0;
            buf_c_en    = 1'b0;
            buf_d_en    = 1'b0;
            buf_a_flush = 1'b1;
            buf_b_flush = 1'b1;
            buf_c_flush = 1'b1;
        end else if (mem_hold) begin
            pc_en        = 1'b0;
            buf_a_en     = 1'b0;
            buf_b_en     = 1'b0;
            buf_c_en     = 1'b0;
            buf_d_en     = 1'b0;
            state_next_s = ST_HOLD;
        end else begin
            case (state_r)
                ST_RUN, ST_HOLD: begin
                    if (taken_s) begin
                        pc_sel_branch = 1'b1;
                        buf_a_flush   = 1'b1;
                        buf_b_flush   = 1'b1;
                        buf_c_flush   = 1'b1;
                        state_next_s  = ST_FLUSH;
                    end else if (lu_s) begin
                        pc_en       = 1'b0;
                        buf_a_en    = 1'b0;
                        buf_b_flush = 1'b1;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // ID/EX/MEM carry bubbles: events are ignored.
                    state_next_s = ST_RUN;
                end
                default: begin
                    // Unreachable encoding: squash everything and recover.
                    pc_en       = 1'b0;
                    buf_a_en    = 1'b0;
                    buf_b_en    = 1'b0;
                    buf_c_en    = 1'b0;
                    buf_d_en    = 1'b0;
                    buf_a_flush = 1'b1;
                    buf_b_flush = 1'b1;
                    buf_c_flush = 1'b1;
                end
            endcase
        end
    end

    // Hold watchdog: counts consecutive frozen cycles, sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r      <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (mem_hold) begin
            wd_r <= sat_inc(wd_r);
            if (wd_r >= HOLD_LIM) begin
                timeout_r <= 1'b1;
            end
        end else begin
            wd_r <= {CNT_W{1'b0}};
        end
    end

    assign state        = state_r;
    assign hold_timeout = timeout_r;

`ifdef PIPELINE_CTRL_PERF_EN
    logic             stall_evt_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] perf_stall_r;
    logic [CNT_W-1:0] perf_flush_r;
    logic [CNT_W-1:0] perf_hold_r;

    assign flush_evt_s = ~mem_hold & (state_r != ST_FLUSH) & taken_s;
    assign stall_evt_s = ~mem_hold & (state_r != ST_FLUSH) & ~taken_s & lu_s;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= {CNT_W{1'b0}};
            perf_flush_r <= {CNT_W{1'b0}};
            perf_hold_r  <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s) perf_stall_r <= sat_inc(perf_stall_r);
            if (flush_evt_s) perf_flush_r <= sat_inc(perf_flush_r);
            if (mem_hold)    perf_hold_r  <= sat_inc(perf_hold_r);
        end
    end

    assign perf_stall_cnt = perf_stall_r;
    assign perf_flush_cnt = perf_flush_r;
    assign perf_hold_cnt  = perf_hold_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected responses
// from a behavioural model; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int REG_W    = 5;
    localparam int CNT_W    = 16;
    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, mem_branch, mem_zf, mem_hold;
    logic             pc_en, pc_sel_branch;
    logic             buf_a_en, buf_b_en, buf_c_en, buf_d_en;
    logic             buf_a_flush, buf_b_flush, buf_c_flush;
    logic [1:0]       state;
    logic             hold_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_hold_cnt;
`endif

    pipeline_ctrl #(.REG_W(REG_W), .HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_branch    (mem_branch),
        .mem_zf        (mem_zf),
        .mem_hold      (mem_hold),
        .pc_en         (pc_en),
        .pc_sel_branch (pc_sel_branch),
        .buf_a_en      (buf_a_en),
        .buf_b_en      (buf_b_en),
        .buf_c_en      (buf_c_en),
        .buf_d_en      (buf_d_en),
        .buf_a_flush   (buf_a_flush),
        .buf_b_flush   (buf_b_flush),
        .buf_c_flush   (buf_c_flush),
        .state         (state),
        .hold_timeout  (hold_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_hold_cnt (perf_hold_cnt)
`endif
    );

    // Output vector order: pc_en pc_sel a_en b_en c_en d_en a_fl b_fl c_fl
    typedef struct {
        logic [8:0] val;
        logic [8:0] care;
        bit         known;
        logic [1:0] st;
        logic       to;
        int         ps, pf, ph;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0, n_fail = 0, n_push = 0, n_pop = 0, cyc_no = 0;

    // Behavioural model state: what happened in the previous cycle.
    bit m_known = 0, m_prev_hold = 0, m_prev_taken = 0, m_to = 0;
    int m_streak = 0, m_ps = 0, m_pf = 0, m_ph = 0;

    task automatic cyc(input bit r, input int rs, input int rt, input bit ut,
                       input bit mr, input int rd, input bit br, input bit zf,
                       input bit hold);
        exp_t e;
        bit tk, lu, in_flush;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0]; id_uses_rt = ut;
        ex_mem_read = mr; ex_rd = rd[REG_W-1:0]; mem_branch = br; mem_zf = zf;
        mem_hold = hold;
        cyc_no++;
        tk = br && zf;
        lu = mr && (rd != 0) && (rd == rs || (ut && rd == rt));
        in_flush = m_prev_taken;
        e.care = 9'h1FF;
        if (r)             e.val = 9'b0_0_0000_111;
        else if (hold)     e.val = 9'b0_0_0000_000;
        else if (in_flush) e.val = 9'b1_0_1111_000;
        else if (tk) begin e.val = 9'b1_1_0001_111; e.care = 9'b1_1_0001_111; end
        else if (lu) begin e.val = 9'b0_0_0011_010; e.care = 9'b1_1_1011_111; end
        else               e.val = 9'b1_0_1111_000;
        e.known = m_known;
        e.st    = m_prev_hold ? 2'd1 : (m_prev_taken ? 2'd2 : 2'd0);
        e.to    = m_to;
        e.ps = m_ps; e.pf = m_pf; e.ph = m_ph;
        e.cyc = cyc_no;
        sbq.push_back(e);
        n_push++;
        if (r) begin
            m_known = 1; m_prev_hold = 0; m_prev_taken = 0; m_to = 0;
            m_streak = 0; m_ps = 0; m_pf = 0; m_ph = 0;
        end else begin
            m_prev_hold  = hold;
            m_prev_taken = !hold && !in_flush && tk;
            if (!hold && !in_flush && !tk && lu) m_ps++;
            if (m_prev_taken) m_pf++;
            if (hold) begin m_ph++; m_streak++; end else m_streak = 0;
            if (m_streak >= HOLD_MAX) m_to = 1;
        end
    endtask

    task automatic idle(input bit hold);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, hold);
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each cycle.
    initial begin
        exp_t me;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                n_pop++;
                act = {pc_en, pc_sel_branch, buf_a_en, buf_b_en, buf_c_en, buf_d_en,
                       buf_a_flush, buf_b_flush, buf_c_flush};
                n_tests++;
                if ((act & me.care) !== (me.val & me.care)) begin
                    n_fail++;
                    $display("FAIL ctrl cyc=%0d got=%b want=%b care=%b", me.cyc, act, me.val, me.care);
                end
                if (me.known) begin
                    n_tests++;
                    if (state !== me.st) begin
                        n_fail++;
                        $display("FAIL state cyc=%0d got=%0d want=%0d", me.cyc, state, me.st);
                    end
                    n_tests++;
                    if (hold_timeout !== me.to) begin
                        n_fail++;
                        $display("FAIL hold_timeout cyc=%0d got=%b want=%b", me.cyc, hold_timeout, me.to);
                    end
`ifdef PIPELINE_CTRL_PERF_EN
                    n_tests++;
                    if (perf_stall_cnt !== CNT_W'(me.ps) || perf_flush_cnt !== CNT_W'(me.pf) ||
                        perf_hold_cnt !== CNT_W'(me.ph)) begin
                        n_fail++;
                        $display("FAIL perf cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", me.cyc,
                                 perf_stall_cnt, perf_flush_cnt, perf_hold_cnt, me.ps, me.pf, me.ph);
                    end
`endif
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int burst;
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; mem_branch = 1'b0; mem_zf = 1'b0; mem_hold = 1'b0;
        // Reset then clean run
        cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        // Load-use on rs, then $zero destination (no stall), then via rt
        cyc(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2, 9, 1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2, 9, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        // Taken branch, then branch together with load-use
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b0, 4, 0, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        // Hold with pending taken branch, released with branch still there
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        // Watchdog: six hold cycles, sticky after release, cleared by reset
        for (int i = 0; i < 6; i++) idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit h;
            if (burst > 0) begin
                h = 1'b1;
                burst--;
            end else if ($urandom_range(0, 29) == 0) begin
                burst = int'($urandom_range(3, 8));
                h = 1'b1;
            end else begin
                h = ($urandom_range(0, 5) == 0);
            end
            cyc($urandom_range(0, 63) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, h);
        end
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (sbq.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL drain got=%0d popped want=%0d", n_pop, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the pc register enable, the branch-target select, and the enable/flush inputs of the four inter-stage buffers: a = IF/ID, b = ID/EX, c = EX/MEM, d = MEM/WB.
- Detects load-use hazards, taken branches resolved in MEM from the EX/MEM zero flag, and external memory-wait holds, and arbitrates between them.
- Adds a hold watchdog.

Parameters:
- REG_W, 5, register-specifier width.
- HOLD_MAX, 255, consecutive hold cycles before hold_timeout sets.
- CNT_W, 16, width of watchdog and perf counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs of instruction in ID.
- id_rt  in  REG_W  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination register of instruction in EX.
- mem_branch  in  1  instruction in MEM is a branch.
- mem_zf  in  1  zero flag from EX/MEM buffer.
- mem_hold  in  1  data/instruction memory not ready.
- pc_en  out  1  pc register load enable.
- pc_sel_branch  out  1  select branch target into pc.
- buf_a_en, buf_b_en, buf_c_en, buf_d_en  out  1 each  buffer load enables.
- buf_a_flush, buf_b_flush, buf_c_flush  out  1 each  load a bubble (all zeros) at next edge.
- state  out  2  FSM state: 0 RUN, 1 HOLD, 2 FLUSH.
- hold_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset
  - Sampled on rising clk only.
  - While rst=1: state→RUN, watchdog and perf counters→0, hold_timeout→0.
  - Combinational outputs during rst=1: all *_en=0, all *_flush=1, pc_sel_branch=0.
- Control outputs are combinational from state and current inputs; they take effect at the next edge.
- Event decode
  - taken = mem_branch & mem_zf.
  - lu = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Priority: hold > taken > lu.
- RUN, no event: all en=1, flushes=0.
- RUN, mem_hold=1
  - All en=0, flushes=0 (full freeze). pc_sel_branch=0 even if taken.
  - next=HOLD.
- RUN, taken (no hold)
  - pc_en=1, pc_sel_branch=1.
  - buf_a_flush=buf_b_flush=buf_c_flush=1; buf_d_en=1.
  - next=FLUSH.
- RUN, lu only (one-cycle bubble)
  - pc_en=0, buf_a_en=0, buf_b_flush=1; buf_c_en=buf_d_en=1.
  - Stay RUN. The bubble clears ex_mem_read, so the stall self-terminates.
- HOLD
  - Freeze as above while mem_hold=1; watchdog increments, saturating at 2^CNT_W−1.
  - When watchdog reaches HOLD_MAX, hold_timeout←1; it clears only on rst.
  - On mem_hold=0: watchdog←0, next=RUN. In that same cycle apply the RUN rules to current inputs, so a held taken branch is not lost.
- FLUSH (one cycle: redirected fetch)
  - All en=1, flushes=0. lu and taken are ignored because ID/EX/MEM hold bubbles.
  - mem_hold=1 overrides: freeze, next=HOLD.
  - Otherwise next=RUN.
- ex_rd=0 never causes a stall, since $zero is never a hazard.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt [CNT_W] (load-use bubbles), perf_flush_cnt [CNT_W] (taken branches) and perf_hold_cnt [CNT_W] (hold cycles).
  - Each counter increments by 1 per qualifying cycle, saturates, and resets to 0 on rst.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants ST_RUN=0, ST_HOLD=1, ST_FLUSH=2;
  - REG_W;
  - the bubble value used by buffer flushes.
- One natural sub-module: hazard_detect (pure combinational lu/taken decode), instantiated once. FSM, watchdog and counters stay in pipeline_ctrl.

Test Plan:
1. rst=1 for 2 cycles then 0 → during rst all en=0, flushes=1, state=0. First cycle after reset with no events → all en=1.
2. ex_mem_read=1, ex_rd=8, id_rs=8 for 1 cycle → pc_en=0, buf_a_en=0, buf_b_flush=1 that cycle; next cycle (ex_mem_read=0) all en=1. Repeat with ex_rd=0 → no stall.
3. mem_branch=1, mem_zf=1 → pc_sel_branch=1, flushes a/b/c=1, state=2 next cycle, then state=0. Same cycle with lu also true → branch wins, pc_en=1.
4. mem_hold=1 with taken=1 for 3 cycles, then 0 → 3 frozen cycles (state=1); on release cycle pc_sel_branch=1 and flushes asserted.
5. HOLD_MAX=4, mem_hold=1 for 6 cycles → hold_timeout=1 from the 5th cycle; stays 1 after release until rst.
6. With PIPELINE_CTRL_PERF_EN: 2 load-use stalls, 1 taken branch, 3 hold cycles → perf_stall_cnt=2, perf_flush_cnt=1, perf_hold_cnt=3; after rst all =0.
